// File: rtl/ext_mem_arb_if.sv
// Word-wide requester port of ext_mem_arb: one request/grant channel plus a
// one-cycle-delayed response channel.
interface ext_mem_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Handshake: an access is accepted in the cycle where req && gnt are both high;
  // the requester holds req/we/be/addr/wdata stable until then. Exactly one
  // cycle after acceptance the port sees rvalid with rdata/err for that access.
  logic                    req;
  logic                    gnt;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ext_mem_arb.sv
// Two-port arbiter in front of the single-port external memory: fixed priority
// to port 0 with a starvation guard for port 1, range check and response routing.
module ext_mem_arb #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE     = 'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] MEM_SIZE     = 'h0002_0000,
  parameter int                    STARVE_LIMIT = 4,
  localparam int                   BE_W         = DATA_WIDTH / 8,
  localparam int                   MA_W         = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ext_mem_arb_if.slave          p0,
  ext_mem_arb_if.slave          p1,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [BE_W-1:0]       mem_be_o,
  output logic [MA_W-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0] MEM_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_owner_q, resp_owner_d;
  logic             resp_err_q, resp_err_d;
  logic             resp_rd_q, resp_rd_d;

  logic            gnt0, gnt1, granted, force1;
  logic            in_range0, in_range1, sel_in_range;
  logic [MA_W-1:0] off0, off1;
  logic            rsp_data_ok;

  // The low MA_W bits of (addr - MEM_BASE) are the memory byte offset.
  assign off0 = p0.addr[MA_W-1:0] - MEM_BASE[MA_W-1:0];
  assign off1 = p1.addr[MA_W-1:0] - MEM_BASE[MA_W-1:0];
  assign in_range0 = ({1'b0, p0.addr} >= {1'b0, MEM_BASE}) && ({1'b0, p0.addr} < MEM_END);
  assign in_range1 = ({1'b0, p1.addr} >= {1'b0, MEM_BASE}) && ({1'b0, p1.addr} < MEM_END);

  always_comb begin
    force1       = (starve_q == CNT_MAX);
    gnt1         = p1.req && (force1 || !p0.req);
    gnt0         = p0.req && !gnt1;
    granted      = gnt0 || gnt1;
    sel_in_range = gnt1 ? in_range1 : in_range0;

    mem_en_o    = granted && sel_in_range;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt1) begin
      mem_we_o    = p1.we;
      mem_be_o    = p1.be;
      mem_addr_o  = off1;
      mem_wdata_o = p1.wdata;
    end else if (gnt0) begin
      mem_we_o    = p0.we;
      mem_be_o    = p0.be;
      mem_addr_o  = off0;
      mem_wdata_o = p0.wdata;
    end

    starve_d = starve_q;
    if (!p1.req || gnt1) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    resp_valid_d = granted;
    resp_owner_d = gnt1;
    resp_err_d   = granted && !sel_in_range;
    resp_rd_d    = granted && !(gnt1 ? p1.we : p0.we);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  // Memory read data is only forwarded for successful reads; writes and errors return zero.
  assign rsp_data_ok = resp_rd_q && !resp_err_q;

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = resp_valid_q && !resp_owner_q;
  assign p1.rvalid = resp_valid_q && resp_owner_q;
  assign p0.err    = p0.rvalid && resp_err_q;
  assign p1.err    = p1.rvalid && resp_err_q;
  assign p0.rdata  = (p0.rvalid && rsp_data_ok) ? mem_rdata_i : '0;
  assign p1.rdata  = (p1.rvalid && rsp_data_ok) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_ext_mem_arb.sv
// Directed bench for ext_mem_arb: drivers push expected responses, a monitor
// pops and compares them whenever a port shows rvalid.
module tb_ext_mem_arb;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 17;

  logic          clk;
  logic          rst_ni;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  ext_mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  ext_mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  ext_mem_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_BASE(32'h0000_1000),
    .MEM_SIZE(32'h0002_0000), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .p0(if0.slave), .p1(if1.slave),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [0:32767];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[16:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[16:2]];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (if0.rvalid) begin
      if (exp_q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL p0_unexpected_rvalid: got rvalid=1 expected 0 @%0t", $time);
      end else check("p0_resp", {if0.err, if0.rdata}, exp_q0.pop_front());
    end
    if (if1.rvalid) begin
      if (exp_q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL p1_unexpected_rvalid: got rvalid=1 expected 0 @%0t", $time);
      end else check("p1_resp", {if1.err, if1.rdata}, exp_q1.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int port, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      if0.req = req; if0.we = we; if0.be = be; if0.addr = addr; if0.wdata = wdata;
    end else begin
      if1.req = req; if1.we = we; if1.be = be; if1.addr = addr; if1.wdata = wdata;
    end
  endtask

  // One access on one port, back-to-back capable; expected response given by caller.
  task automatic issue(input int port, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [MW-1:0] exp_maddr,
                       input logic [31:0] exp_rdata);
    logic got;
    got = 1'b0;
    drive(port, 1'b1, we, be, addr, wdata);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if ((port == 0) ? if0.gnt : if1.gnt) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL gnt_timeout: port %0d got gnt=0 expected 1", port);
    end else begin
      check("other_gnt", (port == 0) ? if1.gnt : if0.gnt, 0);
      check("mem_en", mem_en, !exp_err);
      if (!exp_err) begin
        check("mem_addr", mem_addr, exp_maddr);
        check("mem_we", mem_we, we);
        if (we) begin
          check("mem_be", mem_be, be);
          check("mem_wdata", mem_wdata, wdata);
        end
      end
      if (port == 0) exp_q0.push_back({exp_err, exp_rdata});
      else           exp_q1.push_back({exp_err, exp_rdata});
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Both ports request writes continuously; port 1 must win every 5th cycle.
  task automatic contend(input int start, input int n);
    drive(0, 1'b1, 1'b1, 4'hF, 32'h0000_1800, 32'h0000_00A0);
    drive(1, 1'b1, 1'b1, 4'hF, 32'h0000_1804, 32'h0000_00B1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("contend_gnt", {if0.gnt, if1.gnt}, (((start + k) % 5) == 4) ? 2'b01 : 2'b10);
      if (if0.gnt) exp_q0.push_back(33'h0);
      if (if1.gnt) exp_q1.push_back(33'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(2);
    @(negedge clk);
    check("rst_outputs", {if0.rvalid, if1.rvalid, if0.err, if1.err, if0.gnt, if1.gnt, mem_en}, 0);
    check("rst_rdata", {if0.rdata, if1.rdata}, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    idle(1);

    // write then read the first word through port 0
    issue(0, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 17'h0, 32'h0);
    issue(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0,         1'b0, 17'h0, 32'hDEAD_BEEF);
    idle(2);

    // starvation guard
    contend(0, 15);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(2);

    // range boundaries on port 1
    issue(1, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0, 1'b1, 17'h0, 32'h0);
    issue(1, 1'b0, 4'hF, 32'h0002_1000, 32'h0, 1'b1, 17'h0, 32'h0);
    issue(1, 1'b1, 4'hF, 32'h0002_0FFC, 32'hA5A5_0001, 1'b0, 17'h1FFFC, 32'h0);
    issue(1, 1'b0, 4'hF, 32'h0002_0FFC, 32'h0, 1'b0, 17'h1FFFC, 32'hA5A5_0001);
    idle(2);

    // partial byte-enable write
    issue(1, 1'b1, 4'hF,    32'h0000_1100, 32'hFFFF_FFFF, 1'b0, 17'h100, 32'h0);
    issue(1, 1'b1, 4'b0011, 32'h0000_1100, 32'h1234_5678, 1'b0, 17'h100, 32'h0);
    issue(1, 1'b0, 4'hF,    32'h0000_1100, 32'h0,         1'b0, 17'h100, 32'hFFFF_5678);
    idle(2);

    // alternating owners, distinct data per word
    for (int i = 0; i < 4; i++)
      issue(0, 1'b1, 4'hF, 32'h0000_1200 + 4*i, 32'hA000_0000 + i, 1'b0, 17'h200 + 4*i, 32'h0);
    for (int i = 0; i < 4; i++)
      issue(i % 2, 1'b0, 4'hF, 32'h0000_1200 + 4*i, 32'h0, 1'b0, 17'h200 + 4*i, 32'hA000_0000 + i);
    // port 1 write then port 0 read of the same word in consecutive cycles
    issue(1, 1'b1, 4'hF, 32'h0000_1200, 32'h5555_AAAA, 1'b0, 17'h200, 32'h0);
    issue(0, 1'b0, 4'hF, 32'h0000_1200, 32'h0,         1'b0, 17'h200, 32'h5555_AAAA);
    idle(2);

    // reset in the cycle of a port 0 read grant, with port 1 partly starved
    contend(0, 2);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
    @(negedge clk);
    check("pre_rst_gnt", {if0.gnt, if1.gnt}, 2'b10);
    #1 rst_ni = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("in_rst_rvalid", {if0.rvalid, if1.rvalid}, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    idle(3);
    contend(0, 10);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(2);
    issue(0, 1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 1'b0, 17'h0, 32'h0);
    issue(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0,         1'b0, 17'h0, 32'hCAFE_F00D);
    idle(4);

    check("p0_queue_drained", exp_q0.size(), 0);
    check("p1_queue_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
